// File: rtl/tinyml_requant_ci_if.sv
// Custom-instruction cmd/rsp bus for tinyml_requant_ci.
// master = CPU side, slave = requant unit.
interface tinyml_requant_ci_if;
  logic        cmd_valid;
  logic [9:0]  cmd_function_id;
  logic [31:0] cmd_inputs_0;
  logic [31:0] cmd_inputs_1;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [31:0] rsp_outputs_0;
  logic        rsp_ready;

  modport master (
    output cmd_valid,
    output cmd_function_id,
    output cmd_inputs_0,
    output cmd_inputs_1,
    output rsp_ready,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_outputs_0
  );

  modport slave (
    input  cmd_valid,
    input  cmd_function_id,
    input  cmd_inputs_0,
    input  cmd_inputs_1,
    input  rsp_ready,
    output cmd_ready,
    output rsp_valid,
    output rsp_outputs_0
  );
endinterface

// File: rtl/tinyml_requant_ci.sv
// int32->int8 TFLite requant custom instruction, one outstanding cmd.
// Ports: clk, rstn (async low), bus (cmd/rsp slave, see _if).
module tinyml_requant_ci #(
  parameter int LATENCY = 4
) (
  input logic                clk,
  input logic                rstn,
  tinyml_requant_ci_if.slave bus
);
  localparam int CW = $clog2(LATENCY);
  localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);
  localparam logic signed [63:0] NUDGE_P = 64'sd1073741824;
  localparam logic signed [63:0] NUDGE_N = -64'sd1073741823;
  localparam logic signed [63:0] RND_TZ = 64'sd2147483647;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] stg;

  logic       accept;
  logic       hs;
  logic [2:0] op;
  logic       op_mult;
  logic       op_out;
  logic       op_rq;
  logic       op_cnt;

  assign accept  = bus.cmd_valid & bus.cmd_ready;
  assign hs      = bus.rsp_valid & bus.rsp_ready;
  assign op      = bus.cmd_function_id[2:0];
  assign op_mult = (op == 3'd0);
  assign op_out  = (op == 3'd1);
  assign op_rq   = (op == 3'd2);
  assign op_cnt  = (op == 3'd3);

  logic signed [31:0] mult;
  logic signed [31:0] offset;
  logic signed [5:0]  shift;
  logic signed [7:0]  act_min;
  logic signed [7:0]  act_max;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mult    <= 32'sh4000_0000;
      shift   <= 6'sd1;
      offset  <= '0;
      act_min <= 8'sh80;
      act_max <= 8'sh7F;
    end else if (accept) begin
      if (op_mult) begin
        mult  <= bus.cmd_inputs_0;
        shift <= bus.cmd_inputs_1[5:0];
      end
      if (op_out) begin
        offset  <= bus.cmd_inputs_0;
        act_min <= bus.cmd_inputs_1[7:0];
        act_max <= bus.cmd_inputs_1[15:8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = op_rq ? CALC : RESP;
      CALC: if (stg == LAST) state_nx = RESP;
      RESP: if (bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    unique case (state)
      IDLE: bus.cmd_ready = 1'b1;
      RESP: bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      stg <= '0;
    else if (accept && op_rq)
      stg <= CW'(1);
    else if (state == CALC)
      stg <= stg + 1'b1;
  end

  logic [4:0] ls;
  logic [5:0] rs;

  assign ls = shift[5] ? 5'd0 : shift[4:0];
  assign rs = shift[5] ? (~shift + 6'd1) : 6'd0;

  // Datapath: operands -> left shift -> 64b product -> round/clamp.
  // Stages free-run; config is stable while a command is in flight.
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [31:0]        x_q;
  logic signed [63:0] p_q;
  logic               sat_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q   <= '0;
      b_q   <= '0;
      x_q   <= '0;
      p_q   <= '0;
      sat_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q <= bus.cmd_inputs_0;
        b_q <= bus.cmd_inputs_1;
      end
      x_q   <= (a_q + b_q) << ls;
      p_q   <= $signed({{32{x_q[31]}}, x_q})
             * $signed({{32{mult[31]}}, mult});
      sat_q <= (x_q == 32'h8000_0000)
             && (mult == 32'sh8000_0000);
    end
  end

  logic signed [63:0] q;
  logic signed [63:0] qa;
  logic [31:0]        sr;
  logic [31:0]        mask;
  logic [31:0]        rem;
  logic [31:0]        thr;
  logic signed [31:0] sh;
  logic [31:0]        y;
  logic signed [32:0] sum;
  logic signed [32:0] mn;
  logic signed [32:0] mx;
  logic signed [32:0] lo;
  logic signed [32:0] hi;
  logic [31:0]        result;

  always_comb begin
    q    = p_q + (p_q[63] ? NUDGE_N : NUDGE_P);
    // bias negatives so the arithmetic shift truncates toward zero
    qa   = q[63] ? (q + RND_TZ) : q;
    sr   = sat_q ? 32'h7FFF_FFFF : qa[62:31];
    mask = 32'((33'd1 << rs) - 33'd1);
    rem  = sr & mask;
    thr  = (mask >> 1) + {31'd0, sr[31]};
    sh   = $signed(sr) >>> rs;
    y    = sh + {31'd0, (rem > thr)};
    sum  = $signed({y[31], y})
         + $signed({offset[31], offset});
    mn   = $signed({{25{act_min[7]}}, act_min});
    mx   = $signed({{25{act_max[7]}}, act_max});
    lo   = (sum < mn) ? mn : sum;
    hi   = (lo > mx) ? mx : lo;
    result = {{24{hi[7]}}, hi[7:0]};
  end

  logic [31:0] rsp_data;
  logic [31:0] rq_cnt;
  logic        pend_rq;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_data <= '0;
      rq_cnt   <= '0;
      pend_rq  <= 1'b0;
    end else begin
      if (accept) begin
        pend_rq  <= op_rq;
        rsp_data <= op_cnt ? rq_cnt : 32'd0;
      end else if (state == CALC && stg == LAST) begin
        rsp_data <= result;
      end
      if (hs && pend_rq)
        rq_cnt <= rq_cnt + 32'd1;
    end
  end

  assign bus.rsp_outputs_0 = rsp_data;

  logic unused;
  assign unused = ^{bus.cmd_function_id[9:3], qa[63],
                    qa[30:0], hi[32:8]};
endmodule

// File: tb/tb_tinyml_requant_ci.sv
// Directed bench for tinyml_requant_ci.
// Hand-computed requant vectors, latency, backpressure, reset.
module tb_tinyml_requant_ci;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  tinyml_requant_ci_if bus();

  tinyml_requant_ci #(.LATENCY(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cmd(input string tag,
                     input logic [9:0] fid,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [31:0] exp_d,
                     input int exp_lat);
    int lat;
    int w;
    logic [31:0] d;
    @(negedge clk);
    w = 0;
    while (!bus.cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_function_id = fid;
    bus.cmd_inputs_0 = a;
    bus.cmd_inputs_1 = b;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    d = bus.rsp_outputs_0;
    check({tag, "_data"}, 64'(d), 64'(exp_d));
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] st();
    return {30'd0, bus.rsp_valid, bus.cmd_ready,
            bus.rsp_outputs_0};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    bus.cmd_valid = 1'b0;
    bus.cmd_function_id = '0;
    bus.cmd_inputs_0 = '0;
    bus.cmd_inputs_1 = '0;
    bus.rsp_ready = 1'b1;
    #1;
    check("rst_out", st(), {30'd0, 1'b0, 1'b1, 32'd0});
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    #1;
    check("rst_rel", st(), {30'd0, 1'b0, 1'b1, 32'd0});

    // default identity scaling
    cmd("rq100", 10'h202, 32'd100, 32'd0, 32'h64, 4);
    cmd("rq300", 10'h202, 32'd300, 32'd0, 32'h7F, 4);
    cmd("rqm300", 10'h202, -32'sd300, 32'd0,
        32'hFFFF_FF80, 4);
    cmd("cnt3", 10'h203, 32'd7, 32'd9, 32'd3, 1);

    // shift -1, offset -10
    cmd("smult1", 10'h200, 32'h4000_0000, 32'h3F, 32'd0, 1);
    cmd("sout1", 10'h201, 32'hFFFF_FFF6, 32'h7F80, 32'd0, 1);
    cmd("rq100b", 10'h202, 32'd100, 32'd0, 32'h0F, 4);
    cmd("rqm102", 10'h202, -32'sd102, 32'd0,
        32'hFFFF_FFDC, 4);
    cmd("rqab", 10'h3FA, 32'd50, 32'd50, 32'h0F, 4);

    // saturating doubling-high-mul corner
    cmd("smult2", 10'h200, 32'h8000_0000, 32'h0, 32'd0, 1);
    cmd("sout2", 10'h201, 32'h0, 32'h7F80, 32'd0, 1);
    cmd("rqsat", 10'h202, 32'h8000_0000, 32'd0, 32'h7F, 4);

    cmd("op6", 10'h2AE, 32'h1234_5678, 32'hFFFF, 32'd0, 1);

    // inverted and narrow clamp windows
    cmd("smult3", 10'h200, 32'h4000_0000, 32'h1, 32'd0, 1);
    cmd("sout3", 10'h201, 32'h0, 32'h0A14, 32'd0, 1);
    cmd("rqinv", 10'h202, 32'd0, 32'd0, 32'h0A, 4);
    cmd("sout4", 10'h201, 32'h0, 32'h05FB, 32'd0, 1);
    cmd("rqhi", 10'h202, 32'd100, 32'd0, 32'h05, 4);
    cmd("rqlo", 10'h202, -32'sd100, 32'd0,
        32'hFFFF_FFFB, 4);

    // backpressure; 10 requants completed so far
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_function_id = 10'h202;
    bus.cmd_inputs_0 = 32'd100;
    bus.cmd_inputs_1 = 32'd0;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("bp_first", st(), {30'd0, 1'b1, 1'b0, 32'd5});
    bus.cmd_valid = 1'b1;
    bus.cmd_function_id = 10'h203;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold", st(), {30'd0, 1'b1, 1'b0, 32'd5});
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_hs", {62'd0, bus.rsp_valid, bus.cmd_ready},
          64'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    check("bp_cnt", {31'd0, bus.rsp_valid,
                     bus.rsp_outputs_0},
          {31'd0, 1'b1, 32'd11});
    @(posedge clk);
    #1;

    // reset two cycles into a requant
    cmd("smult5", 10'h200, 32'h4000_0000, 32'h3F, 32'd0, 1);
    cmd("sout5", 10'h201, 32'hFFFF_FFF6, 32'h7F80, 32'd0, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_function_id = 10'h202;
    bus.cmd_inputs_0 = 32'd100;
    bus.cmd_inputs_1 = 32'd0;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("mid_rst", st(), {30'd0, 1'b0, 1'b1, 32'd0});
    seen = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) seen = 1;
    end
    check("mid_novalid", 64'(seen), 64'd0);
    check("mid_ready", {63'd0, bus.cmd_ready}, 64'd1);
    cmd("post_rq", 10'h202, 32'd100, 32'd0, 32'h64, 4);
    cmd("post_cnt", 10'h203, 32'd0, 32'd0, 32'd1, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
